// File: rtl/lut_cfg_loader_if.sv
// rtl/lut_cfg_loader_if.sv - mask word stream into the LUT config loader
interface lut_cfg_loader_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lut_cfg_loader.sv
// rtl/lut_cfg_loader.sv - serialises NUM_LUTS 16-bit LUT masks into the scff chain
// Every output, including in_ready, is a flop; next-cycle values are precomputed.
module lut_cfg_loader #(
  parameter int NUM_LUTS = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  lut_cfg_loader_if.slave  cfg,
  output logic             sc_d,
  output logic             sc_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int WW = $clog2(NUM_LUTS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t        state;
  logic [15:0]   sr;
  logic [4:0]    bcnt;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tcnt;
  logic          in_ready_q;
  logic          accept;
  logic [4:0]    bcnt_nxt;
  logic [WW-1:0] wcnt_nxt;

  assign cfg.in_ready = in_ready_q;
  assign accept       = cfg.in_valid & in_ready_q;

  // bcnt counts bits still to appear on sc_d, including the one shown this cycle
  always_comb begin
    bcnt_nxt = bcnt;
    wcnt_nxt = wcnt;
    if (accept) begin
      bcnt_nxt = 5'd16;
      wcnt_nxt = wcnt + WW'(1);
    end else if (bcnt != 5'd0) begin
      bcnt_nxt = bcnt - 5'd1;
    end
  end

  always_ff @(posedge C) begin
    if (!R) begin
      state      <= S_IDLE;
      sr         <= '0;
      bcnt       <= '0;
      wcnt       <= '0;
      tcnt       <= '0;
      in_ready_q <= 1'b0;
      sc_d       <= 1'b0;
      sc_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      sc_en <= 1'b0;
      sc_d  <= 1'b0;
      case (state)
        S_IDLE: begin
          busy       <= 1'b0;
          in_ready_q <= 1'b0;
          if (start) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            in_ready_q <= 1'b1;
            sr         <= '0;
            bcnt       <= '0;
            wcnt       <= '0;
            tcnt       <= '0;
          end
        end
        S_LOAD: begin
          bcnt       <= bcnt_nxt;
          wcnt       <= wcnt_nxt;
          in_ready_q <= (bcnt_nxt == 5'd0) ||
                        (bcnt_nxt == 5'd1 && wcnt_nxt < WW'(NUM_LUTS));
          if (accept) begin
            sr    <= cfg.in_data >> 1;
            sc_d  <= cfg.in_data[0];
            sc_en <= 1'b1;
          end else if (bcnt > 5'd1) begin
            sr    <= sr >> 1;
            sc_d  <= sr[0];
            sc_en <= 1'b1;
          end
          if (accept)
            tcnt <= '0;
          else if (bcnt == 5'd0 && !cfg.in_valid)
            tcnt <= tcnt + TW'(1);
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            in_ready_q <= 1'b0;
            sc_en      <= 1'b0;
            sc_d       <= 1'b0;
          end else if (bcnt == 5'd1 && !accept && wcnt == WW'(NUM_LUTS)) begin
            state      <= S_DONE;
            done       <= 1'b1;
            in_ready_q <= 1'b0;
          end else if (bcnt == 5'd0 && !cfg.in_valid && tcnt == TW'(TIMEOUT - 1)) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            err        <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          in_ready_q <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb/tb_lut_cfg_loader.sv - directed bench for lut_cfg_loader (NUM_LUTS=8, TIMEOUT=16)
module tb_lut_cfg_loader;
  logic C = 1'b0;
  logic R = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sc_d, sc_en, busy, done, err;

  lut_cfg_loader_if cfg();

  lut_cfg_loader #(.NUM_LUTS(8), .TIMEOUT(16)) dut (
    .C(C), .R(R), .start(start), .abort(abort), .cfg(cfg),
    .sc_d(sc_d), .sc_en(sc_en), .busy(busy), .done(done), .err(err)
  );

  always #5 C = ~C;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // per-cycle record: {in_ready, sc_en, busy, done, err}
  logic [4:0]   stat_log [0:255];
  int           acc_cyc [0:7];
  int           n_acc, n_bits, first_en, last_en, done_cyc, err_cyc, n_done, n_err;
  logic [127:0] bits;

  // cycle 0 carries start; words are k+1 in acceptance order
  task automatic run(input int n_cyc, input int gap_lo, input int gap_hi, input int stop_after,
                     input int abort_at, input int start_a, input int start_b, input int rst_at);
    n_acc = 0; n_bits = 0; first_en = -1; last_en = -1;
    done_cyc = -1; err_cyc = -1; n_done = 0; n_err = 0; bits = '0;
    for (int k = 0; k < 8; k++) acc_cyc[k] = -1;
    for (int c = 0; c < n_cyc; c++) begin
      start        = (c == 0) || (c == start_a) || (c == start_b);
      abort        = (c == abort_at);
      R            = (c != rst_at);
      cfg.in_valid = (c >= 1) && (n_acc < stop_after) && !(c >= gap_lo && c <= gap_hi);
      cfg.in_data  = 16'(n_acc + 1);
      @(negedge C);
      stat_log[c] = {cfg.in_ready, sc_en, busy, done, err};
      if (cfg.in_valid && cfg.in_ready) begin
        if (n_acc < 8) acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (sc_en) begin
        if (n_bits < 128) bits[n_bits] = sc_d;
        n_bits++;
        if (first_en < 0) first_en = c;
        last_en = c;
      end
      if (done) begin n_done++; done_cyc = c; end
      if (err) begin n_err++; err_cyc = c; end
      @(posedge C);
      #1;
    end
    start = 1'b0; abort = 1'b0; R = 1'b1; cfg.in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_bits;
    logic [6:0]   en_win;
    for (int k = 0; k < 8; k++) exp_bits[16*k +: 16] = 16'(k + 1);
    cfg.in_valid = 1'b0;
    cfg.in_data  = '0;

    R = 1'b0; start = 1'b1;
    @(posedge C);
    @(posedge C);
    @(negedge C);
    expect_eq("reset_outputs", {cfg.in_ready, sc_en, busy, done, err}, 5'b0);
    R = 1'b1; start = 1'b0;
    @(posedge C);
    #1;

    run(140, -1, -1, 8, -1, -1, -1, -1);
    for (int k = 0; k < 8; k++) expect_eq("b2b_accept_cycle", acc_cyc[k], 1 + 16 * k);
    expect_eq("b2b_first_en", first_en, 2);
    expect_eq("b2b_last_en", last_en, 129);
    expect_eq("b2b_en_count", n_bits, 128);
    expect_eq("b2b_word0_bits", bits[15:0], 16'h0001);
    expect_eq("b2b_stream", bits, exp_bits);
    expect_eq("b2b_done_cycle", done_cyc, 130);
    expect_eq("b2b_done_count", n_done, 1);
    expect_eq("b2b_err_count", n_err, 0);
    expect_eq("b2b_busy_at_done", stat_log[130][2], 1'b1);
    expect_eq("b2b_busy_after", stat_log[131][2], 1'b0);

    run(145, 33, 37, 8, -1, -1, -1, -1);
    for (int i = 0; i < 7; i++) en_win[6 - i] = stat_log[33 + i][3];
    expect_eq("stall_en_window", en_win, 7'b1000001);
    expect_eq("stall_word2_accept", acc_cyc[2], 38);
    expect_eq("stall_en_count", n_bits, 128);
    expect_eq("stall_stream", bits, exp_bits);
    expect_eq("stall_done_cycle", done_cyc, 135);

    run(60, -1, -1, 2, -1, -1, -1, -1);
    expect_eq("tmo_last_en", last_en, 33);
    expect_eq("tmo_stream", bits[31:0], 32'h0002_0001);
    expect_eq("tmo_err_count", n_err, 1);
    expect_eq("tmo_err_cycle", err_cyc, 50);
    expect_eq("tmo_done_count", n_done, 0);
    expect_eq("tmo_busy_before", stat_log[49][2], 1'b1);
    expect_eq("tmo_busy_after", stat_log[51][2], 1'b0);

    run(70, -1, -1, 8, 57, -1, -1, -1);
    expect_eq("abort_word3_accept", acc_cyc[3], 49);
    expect_eq("abort_en_before", stat_log[57][3], 1'b1);
    expect_eq("abort_en_after", stat_log[58][3], 1'b0);
    expect_eq("abort_busy_after", stat_log[58][2], 1'b0);
    expect_eq("abort_en_count", n_bits, 56);
    expect_eq("abort_done_err", {n_done[3:0], n_err[3:0]}, 8'h00);

    run(140, -1, -1, 8, -1, -1, -1, -1);
    expect_eq("reload_stream", bits, exp_bits);
    expect_eq("reload_done_cycle", done_cyc, 130);

    run(140, -1, -1, 8, -1, 60, 130, -1);
    expect_eq("restart_last_accept", acc_cyc[7], 113);
    expect_eq("restart_stream", bits, exp_bits);
    expect_eq("restart_done_cycle", done_cyc, 130);
    expect_eq("restart_done_count", n_done, 1);
    expect_eq("restart_idle_after_done", stat_log[131][2], 1'b0);

    run(80, -1, -1, 8, -1, -1, -1, 70);
    expect_eq("midrst_en_before", stat_log[70][3], 1'b1);
    expect_eq("midrst_outputs", stat_log[71], 5'b0);
    expect_eq("midrst_done_count", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
